// File: rtl/f1_sequencer.sv
// Pacing controller for the F1 start-light FSM: eight tick-spaced step pulses,
// then a pseudo-random hold of 1..127 ticks before the lights-out pulse.
module f1_sequencer #(
  parameter int         WIDTH     = 16,
  parameter logic [6:0] LFSR_SEED = 7'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [WIDTH-1:0] tick_period,
  output logic             en,
  output logic             busy,
  output logic             lights_out,
  output logic [6:0]       delay_ticks
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DELAY = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pre;
  logic [2:0]       step;
  logic [6:0]       dcnt;
  logic [6:0]       lfsr;
  logic             tick;
  logic             last;

  // Outputs decode only registered state, so input changes never reach en.
  always_comb begin
    tick       = (pre == '0);
    last       = (state == S_DELAY) && (dcnt == 7'd1);
    en         = tick && ((state == S_COUNT) || last);
    lights_out = tick && last;
    busy       = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pre         <= '0;
      step        <= '0;
      dcnt        <= '0;
      delay_ticks <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[2]};
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state <= S_COUNT;
            pre   <= tick_period;
            step  <= '0;
          end
        end
        S_COUNT: begin
          if (tick) begin
            pre  <= tick_period;
            step <= step + 3'd1;
            if (step == 3'd7) begin
              state       <= S_DELAY;
              dcnt        <= lfsr;
              delay_ticks <= lfsr;
            end
          end else begin
            pre <= pre - WIDTH'(1);
          end
        end
        S_DELAY: begin
          if (tick) begin
            pre <= tick_period;
            if (dcnt == 7'd1) state <= S_IDLE;
            else              dcnt  <= dcnt - 7'd1;
          end else begin
            pre <= pre - WIDTH'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_sequencer.sv
// Directed bench for f1_sequencer: pulse timing, hold length, retrigger immunity,
// mid-sequence reset and LFSR-dependent hold values.
module tb_f1_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             trigger;
  logic [WIDTH-1:0] tick_period;
  logic             en;
  logic             busy;
  logic             lights_out;
  logic [6:0]       delay_ticks;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] m_lfsr;

  f1_sequencer #(.WIDTH(WIDTH), .LFSR_SEED(7'h01)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .tick_period (tick_period),
    .en          (en),
    .busy        (busy),
    .lights_out  (lights_out),
    .delay_ticks (delay_ticks)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed on reset, x^7+x^3+1 Fibonacci step every cycle.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 7'h01;
    else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Trigger one sequence and check every pulse against E0-relative timing.
  task automatic run_seq(input int tp, input bit retrig, output int d_seen);
    int         c;
    int         np;
    int         t8;
    int         exp_d;
    int         p;
    logic [7:0] lamps;
    bit         done;
    p      = tp + 1;
    np     = 0;
    t8     = 0;
    exp_d  = 0;
    lamps  = 8'h00;
    done   = 1'b0;
    tick_period = WIDTH'(tp);
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    c = 0;
    chk("busy_rise", int'(busy), 1);
    while (!done && c < 3000) begin
      trigger = retrig && (c == 1 || (np == 8 && c == t8 + 2));
      if (np == 8 && c == t8 + 1) chk("delay_ticks_latch", int'(delay_ticks), exp_d);
      if (en) begin
        np++;
        lamps = (lamps == 8'hFF) ? 8'h00 : {lamps[6:0], 1'b1};
        if (np <= 8) begin
          chk($sformatf("pulse%0d_time", np), c, np * p - 1);
          chk($sformatf("pulse%0d_lo", np), int'(lights_out), 0);
        end
        if (np == 8) begin
          t8    = c;
          exp_d = int'(m_lfsr);
          chk("lamps_full", int'(lamps), 8'hFF);
        end
        if (np == 9) begin
          chk("pulse9_time", c, t8 + exp_d * p);
          chk("pulse9_lights_out", int'(lights_out), 1);
          chk("lamps_off", int'(lamps), 0);
          done = 1'b1;
        end
      end else if (lights_out) begin
        chk("lights_out_stray", 1, 0);
      end
      if (!busy) chk("busy_hold", int'(busy), 1);
      @(negedge clk);
      c++;
    end
    trigger = 1'b0;
    if (!done) chk("seq_timeout_pulses", np, 9);
    chk("busy_fall", int'(busy), 0);
    chk("d_range", int'(delay_ticks >= 7'd1), 1);
    for (int i = 0; i < 20; i++) begin
      if (en) chk("extra_en", int'(en), 0);
      @(negedge clk);
    end
    chk("idle_after_seq", int'(busy), 0);
    d_seen = exp_d;
  endtask

  initial begin
    int d0;
    int da;
    int db;
    int np;
    int cnt;
    rst         = 1'b1;
    trigger     = 1'b0;
    tick_period = '0;
    repeat (3) @(negedge clk);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lights_out", int'(lights_out), 0);
    chk("rst_delay_ticks", int'(delay_ticks), 0);
    rst = 1'b0;

    run_seq(3, 1'b0, d0);
    run_seq(0, 1'b0, d0);
    run_seq(3, 1'b1, d0);
    run_seq(1, 1'b1, d0);

    // Reset after pulse 5 must kill the sequence and clear the outputs.
    tick_period = WIDTH'(3);
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    np = 0;
    for (int i = 0; i < 100 && np < 5; i++) begin
      if (en) np++;
      if (np < 5) @(negedge clk);
    end
    chk("rst_mid_reached5", np, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_en", int'(en), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_lights_out", int'(lights_out), 0);
    chk("rst_mid_delay_ticks", int'(delay_ticks), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (en) cnt++;
    end
    chk("rst_mid_no_en", cnt, 0);

    // Sequences started one cycle apart from reset see different hold lengths.
    do_reset();
    run_seq(0, 1'b0, da);
    do_reset();
    @(negedge clk);
    run_seq(0, 1'b0, db);
    chk("d_offsets_differ", int'(da != db), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
